// File: rtl/fifo_ctrl_if.sv
// Handshake/status bundle between a FIFO user and fifo_ctrl.
//   master : request side (drives wr_i, rd_i, clr_err_i; observes everything else)
//   slave  : fifo_ctrl (drives enables, addresses, occupancy and status flags)
// Signal names keep the original port names of fifo_ctrl.
interface fifo_ctrl_if #(
    parameter int unsigned AddrBits = 3
);
    logic                wr_i;
    logic                rd_i;
    logic                clr_err_i;
    logic                wr_en_o;
    logic                rd_en_o;
    logic [AddrBits-1:0] w_addr_o;
    logic [AddrBits-1:0] r_addr_o;
    logic                r_valid_o;
    logic                full_o;
    logic                empty_o;
    logic                almost_full_o;
    logic                almost_empty_o;
    logic [AddrBits:0]   count_o;
    logic                overflow_o;
    logic                underflow_o;

    modport master (
        output wr_i, rd_i, clr_err_i,
        input  wr_en_o, rd_en_o, w_addr_o, r_addr_o, r_valid_o,
               full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );

    modport slave (
        input  wr_i, rd_i, clr_err_i,
        output wr_en_o, rd_en_o, w_addr_o, r_addr_o, r_valid_o,
               full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a synchronous FIFO built on a reg_file of
// 2**AddrBits entries. Gates push/pop requests against registered full/empty,
// drives the storage write/read enables and addresses, and publishes occupancy,
// almost-full/almost-empty and sticky overflow/underflow status.
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rst_i  : synchronous active-high reset
//   fifo   : fifo_ctrl_if slave (wr_i/rd_i/clr_err_i in; enables, addresses,
//            r_valid_o, flags, count_o, overflow_o/underflow_o out)
module fifo_ctrl #(
    parameter int unsigned AddrBits       = 3,
    parameter int unsigned AlmostFullThr  = 6,
    parameter int unsigned AlmostEmptyThr = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    fifo_ctrl_if.slave fifo
);
    localparam int unsigned      Depth  = 1 << AddrBits;
    localparam logic [AddrBits:0] DepthC = (AddrBits + 1)'(Depth);
    localparam logic [AddrBits:0] AfThrC = (AddrBits + 1)'(AlmostFullThr);
    localparam logic [AddrBits:0] AeThrC = (AddrBits + 1)'(AlmostEmptyThr);

    if (AlmostFullThr == 0 || AlmostFullThr > Depth || AlmostEmptyThr >= Depth) begin : g_bad_thr
        $error("fifo_ctrl: threshold parameters out of range");
    end

    logic [AddrBits:0] wptr_q;
    logic [AddrBits:0] rptr_q;
    logic [AddrBits:0] count_q;
    logic [AddrBits:0] count_next;
    logic              full_q;
    logic              empty_q;
    logic              afull_q;
    logic              aempty_q;
    logic              ovf_q;
    logic              unf_q;
    logic              rvalid_q;
    logic              wr_en;
    logic              rd_en;

    // Acceptance looks only at the registered flags, so a pop in the same
    // cycle never frees room for a push into a full FIFO (and vice versa).
    always_comb begin
        wr_en      = fifo.wr_i & ~full_q  & ~rst_i;
        rd_en      = fifo.rd_i & ~empty_q & ~rst_i;
        count_next = count_q + (AddrBits + 1)'(wr_en) - (AddrBits + 1)'(rd_en);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_q + (AddrBits + 1)'(wr_en);
            rptr_q   <= rptr_q + (AddrBits + 1)'(rd_en);
            count_q  <= count_next;
            full_q   <= (count_next == DepthC);
            empty_q  <= (count_next == '0);
            afull_q  <= (count_next >= AfThrC);
            aempty_q <= (count_next <= AeThrC);
            // A new error in the same cycle as a clear wins over the clear.
            ovf_q    <= (fifo.wr_i & full_q)  | (ovf_q & ~fifo.clr_err_i);
            unf_q    <= (fifo.rd_i & empty_q) | (unf_q & ~fifo.clr_err_i);
            rvalid_q <= rd_en;
        end
    end

    assign fifo.wr_en_o        = wr_en;
    assign fifo.rd_en_o        = rd_en;
    assign fifo.w_addr_o       = wptr_q[AddrBits-1:0];
    assign fifo.r_addr_o       = rptr_q[AddrBits-1:0];
    assign fifo.r_valid_o      = rvalid_q;
    assign fifo.full_o         = full_q;
    assign fifo.empty_o        = empty_q;
    assign fifo.almost_full_o  = afull_q;
    assign fifo.almost_empty_o = aempty_q;
    assign fifo.count_o        = count_q;
    assign fifo.overflow_o     = ovf_q;
    assign fifo.underflow_o    = unf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a small reg_file storage driven by the DUT's enables and
// addresses, a queue-based FIFO model, a per-cycle compare process, and
// directed literal checks followed by randomized traffic.
module tb_fifo_ctrl;
    localparam int AB    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr  = 1'b0;
    logic rd  = 1'b0;
    logic clr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] r_data;
    logic [7:0] mem [DEPTH];

    always #5 clk = ~clk;

    fifo_ctrl_if #(.AddrBits(AB)) bus ();

    assign bus.wr_i      = wr;
    assign bus.rd_i      = rd;
    assign bus.clr_err_i = clr;

    fifo_ctrl #(
        .AddrBits      (AB),
        .AlmostFullThr (AF),
        .AlmostEmptyThr(AE)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .fifo (bus)
    );

    // Storage array with a synchronous read port.
    always @(posedge clk) begin
        if (bus.wr_en_o) mem[bus.w_addr_o] <= wdata;
        if (bus.rd_en_o) r_data <= mem[bus.r_addr_o];
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy, pointer positions and a data queue.
    int         m_cnt = 0;
    int         m_wp  = 0;
    int         m_rp  = 0;
    int         m_aw;
    int         m_ar;
    bit         m_ovf = 0;
    bit         m_unf = 0;
    bit         m_rv  = 0;
    logic [7:0] m_rdata;
    logic [7:0] q [$];

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_wp = 0; m_rp = 0;
            m_ovf = 0; m_unf = 0; m_rv = 0;
            q.delete();
        end else begin
            m_aw  = (wr && m_cnt < DEPTH) ? 1 : 0;
            m_ar  = (rd && m_cnt > 0) ? 1 : 0;
            m_ovf = (wr && m_cnt == DEPTH) || (m_ovf && !clr);
            m_unf = (rd && m_cnt == 0) || (m_unf && !clr);
            m_rv  = (m_ar == 1);
            if (m_ar == 1) m_rdata = q.pop_front();
            if (m_aw == 1) q.push_back(wdata);
            m_cnt = m_cnt + m_aw - m_ar;
            m_wp  = (m_wp + m_aw) % DEPTH;
            m_rp  = (m_rp + m_ar) % DEPTH;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("wr_en",        bus.wr_en_o,        32'(wr && m_cnt < DEPTH && !rst));
            chk("rd_en",        bus.rd_en_o,        32'(rd && m_cnt > 0 && !rst));
            chk("count",        bus.count_o,        32'(m_cnt));
            chk("full",         bus.full_o,         32'(m_cnt == DEPTH));
            chk("empty",        bus.empty_o,        32'(m_cnt == 0));
            chk("almost_full",  bus.almost_full_o,  32'(m_cnt >= AF));
            chk("almost_empty", bus.almost_empty_o, 32'(m_cnt <= AE));
            chk("w_addr",       bus.w_addr_o,       32'(m_wp));
            chk("r_addr",       bus.r_addr_o,       32'(m_rp));
            chk("overflow",     bus.overflow_o,     32'(m_ovf));
            chk("underflow",    bus.underflow_o,    32'(m_unf));
            chk("r_valid",      bus.r_valid_o,      32'(m_rv));
            if (m_rv) chk("r_data", r_data, m_rdata);
        end
    end

    task automatic drive(input logic w, input logic r, input logic c, input logic rs);
        wr = w; rd = r; clr = c; rst = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pw;

    initial begin
        // 1. reset then idle
        drive(0, 0, 0, 1);
        tick();
        chk_on = 1;
        drive(0, 0, 0, 0);
        #1;
        chk("t1_wr_en", bus.wr_en_o, 0);
        chk("t1_rd_en", bus.rd_en_o, 0);
        tick();
        chk("t1_count", bus.count_o, 0);
        chk("t1_empty", bus.empty_o, 1);
        chk("t1_aempty", bus.almost_empty_o, 1);
        chk("t1_full", bus.full_o, 0);
        chk("t1_rvalid", bus.r_valid_o, 0);

        // 2. eight back-to-back pushes
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0);
            wdata = 8'(8'h10 + i);
            #1;
            chk("t2_w_addr", bus.w_addr_o, 32'(i));
            chk("t2_wr_en", bus.wr_en_o, 1);
            tick();
            chk("t2_count", bus.count_o, 32'(i + 1));
            chk("t2_afull", bus.almost_full_o, (i + 1 >= 6) ? 1 : 0);
            chk("t2_full", bus.full_o, (i == 7) ? 1 : 0);
        end

        // 3. push while full, then clear
        drive(1, 0, 0, 0);
        #1;
        chk("t3_wr_en", bus.wr_en_o, 0);
        tick();
        chk("t3_count", bus.count_o, 8);
        chk("t3_ovf", bus.overflow_o, 1);
        drive(0, 0, 1, 0);
        tick();
        chk("t3_ovf_clr", bus.overflow_o, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_drain_data", r_data, 32'(8'h10 + i));
        end
        chk("t3_empty", bus.empty_o, 1);

        // 4. pop while empty with push, then data latency
        drive(1, 1, 0, 0);
        wdata = 8'h33;
        #1;
        chk("t4_rd_en", bus.rd_en_o, 0);
        chk("t4_wr_en", bus.wr_en_o, 1);
        tick();
        chk("t4_count", bus.count_o, 1);
        chk("t4_unf", bus.underflow_o, 1);
        drive(0, 0, 1, 0);
        tick();
        chk("t4_unf_clr", bus.underflow_o, 0);
        drive(0, 1, 0, 0);
        tick();
        chk("t4_data33", r_data, 8'h33);
        drive(1, 0, 0, 0);
        wdata = 8'hA5;
        tick();
        drive(0, 1, 0, 0);
        #1;
        chk("t4_rd_en_a5", bus.rd_en_o, 1);
        tick();
        chk("t4_rvalid", bus.r_valid_o, 1);
        chk("t4_dataA5", r_data, 8'hA5);
        drive(0, 0, 0, 0);
        tick();
        chk("t4_rvalid_off", bus.r_valid_o, 0);

        // 5. fill to 4, then simultaneous push+pop with address wrap
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0);
            wdata = 8'(8'h40 + i);
            tick();
        end
        chk("t5_count4", bus.count_o, 4);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0);
            wdata = 8'($urandom);
            tick();
            chk("t5_count_hold", bus.count_o, 4);
        end

        // 6. reset in the middle of a burst
        drive(1, 1, 0, 1);
        #1;
        chk("t6_wr_en", bus.wr_en_o, 0);
        chk("t6_rd_en", bus.rd_en_o, 0);
        tick();
        chk("t6_count", bus.count_o, 0);
        chk("t6_empty", bus.empty_o, 1);
        chk("t6_aempty", bus.almost_empty_o, 1);
        chk("t6_full", bus.full_o, 0);
        chk("t6_afull", bus.almost_full_o, 0);
        chk("t6_rvalid", bus.r_valid_o, 0);
        chk("t6_w_addr", bus.w_addr_o, 0);

        // Randomized traffic with alternating fill/drain bias
        pw = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) pw = (pw == 70) ? 30 : 70;
            wdata = 8'($urandom);
            drive(($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 100 - pw) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
            tick();
        end
        drive(0, 0, 0, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
